// File: rtl/stash_sequencer_if.sv
// Sample-source / stash bus. The sequencer uses the master modport; the stash and
// sample source sit on the slave side.
interface stash_sequencer_if #(
    parameter int DEPTH = 5
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic          sample_ready;
    logic [7:0]    sample_data;
    logic          sample_in_valid;
    logic [7:0]    sample_in;
    logic          next_sample;
    logic [CW-1:0] stored_count;
    logic [IW-1:0] view_idx;

    modport master (
        input  sample_ready, sample_data,
        output sample_in_valid, sample_in, next_sample, stored_count, view_idx
    );
    modport slave (
        output sample_ready, sample_data,
        input  sample_in_valid, sample_in, next_sample, stored_count, view_idx
    );
endinterface

// File: rtl/stash_sequencer.sv
// Button/auto-scroll sequencer for the sample stash; mirrors its fill count and view index.
// Optional clear path is built when STASH_SEQ_CLEAR_EN is defined.
module stash_sequencer #(
    parameter int DEPTH    = 5,
    parameter int TICK_DIV = 100000000,
    parameter int TIMEOUT  = 50000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_store,
    input  logic               btn_next,
    input  logic               auto_en,
`ifdef STASH_SEQ_CLEAR_EN
    input  logic               btn_clear,
    output logic               stash_clear,
`endif
    stash_sequencer_if.master  bus,
    output logic [1:0]         state,
    output logic               timeout
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DEPTH);
    localparam int TW  = $clog2(TICK_DIV);
    localparam int TOW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, AUTO = 2'd2} state_t;

`ifdef STASH_SEQ_CLEAR_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    // Buttons occupy [NB-1:0] and get edge detection; auto_en is the top bit, level only.
    logic [NB:0]   raw, sync1, sync2;
    logic [NB-1:0] hist, ev;
    logic          store_ev, next_ev, auto_s;

`ifdef STASH_SEQ_CLEAR_EN
    assign raw = {auto_en, btn_clear, btn_next, btn_store};
`else
    assign raw = {auto_en, btn_next, btn_store};
`endif
    assign ev       = sync2[NB-1:0] & ~hist;
    assign store_ev = ev[0];
    assign next_ev  = ev[1];
    assign auto_s   = sync2[NB];

    state_t         state_q, state_nx;
    logic [TW-1:0]  tick_q, tick_nx;
    logic [TOW-1:0] tocnt_q, tocnt_nx;
    logic           vld_q, vld_nx, nxt_q, nxt_nx, to_q, to_nx;
    logic           clr_q, clr_nx;
    logic [7:0]     data_q;
    logic [CW-1:0]  cnt_q;
    logic [IW-1:0]  view_q, wr_q;

    always_comb begin
        state_nx = state_q;
        tick_nx  = tick_q;
        tocnt_nx = tocnt_q;
        vld_nx   = 1'b0;
        nxt_nx   = 1'b0;
        to_nx    = 1'b0;
        clr_nx   = 1'b0;
        unique case (state_q)
            IDLE: begin
`ifdef STASH_SEQ_CLEAR_EN
                // Clear wins over an advance so the zeroed view index is not disturbed.
                if (ev[2])
                    clr_nx = 1'b1;
                else
`endif
                if (next_ev && cnt_q != '0)
                    nxt_nx = 1'b1;
                if (store_ev) begin
                    state_nx = ARMED;
                    tocnt_nx = '0;
                end else if (auto_s) begin
                    state_nx = AUTO;
                    tick_nx  = '0;
                end
            end
            ARMED: begin
                if (bus.sample_ready) begin
                    vld_nx   = 1'b1;
                    state_nx = IDLE;
                end else if (store_ev) begin
                    state_nx = IDLE;
                end else if (tocnt_q == TOW'(TIMEOUT - 1)) begin
                    to_nx    = 1'b1;
                    state_nx = IDLE;
                end else begin
                    tocnt_nx = tocnt_q + 1'b1;
                end
            end
            AUTO: begin
                if (store_ev) begin
                    state_nx = ARMED;
                    tocnt_nx = '0;
                end else if (!auto_s) begin
                    state_nx = IDLE;
                    tick_nx  = '0;
                end else if (tick_q == TW'(TICK_DIV - 1)) begin
                    tick_nx = '0;
                    nxt_nx  = (cnt_q != '0);
                end else begin
                    tick_nx = tick_q + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            hist    <= '0;
            state_q <= IDLE;
            tick_q  <= '0;
            tocnt_q <= '0;
            vld_q   <= 1'b0;
            nxt_q   <= 1'b0;
            to_q    <= 1'b0;
            clr_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            view_q  <= '0;
            wr_q    <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            hist    <= sync2[NB-1:0];
            state_q <= state_nx;
            tick_q  <= tick_nx;
            tocnt_q <= tocnt_nx;
            vld_q   <= vld_nx;
            nxt_q   <= nxt_nx;
            to_q    <= to_nx;
            clr_q   <= clr_nx;
            // Pointers move on the same edge the strobe is registered, so the mirrored
            // count and index are consistent with the strobe cycle itself.
            if (vld_nx) begin
                data_q <= bus.sample_data;
                view_q <= wr_q;
                wr_q   <= (wr_q == IW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
                if (cnt_q != CW'(DEPTH))
                    cnt_q <= cnt_q + 1'b1;
            end
            if (nxt_nx)
                view_q <= (view_q == IW'(DEPTH - 1)) ? '0 : view_q + 1'b1;
            if (clr_nx) begin
                cnt_q  <= '0;
                view_q <= '0;
                wr_q   <= '0;
            end
        end
    end

    assign bus.sample_in_valid = vld_q;
    assign bus.sample_in       = data_q;
    assign bus.next_sample     = nxt_q;
    assign bus.stored_count    = cnt_q;
    assign bus.view_idx        = view_q;
    assign state               = state_q;
    assign timeout             = to_q;
`ifdef STASH_SEQ_CLEAR_EN
    assign stash_clear         = clr_q;
`else
    logic unused_clr;
    assign unused_clr = clr_q;
`endif
endmodule

// File: tb/tb_stash_sequencer.sv
// Scoreboard bench for stash_sequencer: stimulus pushes expected strobes, a negedge
// monitor pops and compares whenever a strobe appears.
module tb_stash_sequencer;
    localparam int DEPTH = 5, TICK_DIV = 8, TIMEOUT = 16;
    localparam logic [2:0] K_STORE = 3'b001, K_NEXT = 3'b010, K_TO = 3'b100;

    logic clk = 1'b0, reset = 1'b1;
    logic btn_store = 1'b0, btn_next = 1'b0, auto_en = 1'b0;
    logic [1:0] state;
    logic timeout;
`ifdef STASH_SEQ_CLEAR_EN
    logic btn_clear = 1'b0, stash_clear;
`endif

    stash_sequencer_if #(.DEPTH(DEPTH)) bus ();

    stash_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .btn_store(btn_store), .btn_next(btn_next), .auto_en(auto_en),
`ifdef STASH_SEQ_CLEAR_EN
        .btn_clear(btn_clear), .stash_clear(stash_clear),
`endif
        .bus(bus.master), .state(state), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        logic [2:0] cnt;
        logic [2:0] idx;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0, n_err = 0, cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void push(logic [2:0] k, logic [7:0] d, logic [2:0] c, logic [2:0] i);
        exp_t e;
        e.kind = k; e.data = d; e.cnt = c; e.idx = i;
        q.push_back(e);
    endfunction

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && (bus.sample_in_valid || bus.next_sample || timeout)) begin
            if (q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_strobe: got %b expected none (t=%0t)",
                         {timeout, bus.next_sample, bus.sample_in_valid}, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("strobe_kind", {29'd0, timeout, bus.next_sample, bus.sample_in_valid}, {29'd0, e.kind});
                check("sample_in", {24'd0, bus.sample_in}, {24'd0, e.data});
                check("stored_count", {29'd0, bus.stored_count}, {29'd0, e.cnt});
                check("view_idx", {29'd0, bus.view_idx}, {29'd0, e.idx});
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(logic [1:0] s, string name);
        int n = 0;
        while (state !== s && n < 40) begin cyc(1); n++; end
        check(name, {30'd0, state}, {30'd0, s});
    endtask

    task automatic wait_next(output int at);
        int n = 0;
        cyc(1);
        while (bus.next_sample !== 1'b1 && n < 40) begin cyc(1); n++; end
        check("next_seen", {31'd0, bus.next_sample}, 32'd1);
        at = cyc_cnt;
    endtask

    task automatic press(int which, int hold);
        if (which == 0) btn_store = 1'b1; else btn_next = 1'b1;
        cyc(hold);
        btn_store = 1'b0; btn_next = 1'b0;
    endtask

    task automatic store_sample(logic [7:0] d, logic [2:0] c, logic [2:0] i);
        press(0, 1);
        wait_state(2'd1, "armed");
        cyc(2);
        push(K_STORE, d, c, i);
        bus.sample_ready = 1'b1; bus.sample_data = d;
        cyc(1);
        bus.sample_ready = 1'b0; bus.sample_data = 8'h00;
        cyc(2);
    endtask

    task automatic do_reset();
        check("queue_drained", q.size(), 0);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(2);
    endtask

    initial begin
        int t0, t1, n;
        bus.sample_ready = 1'b0;
        bus.sample_data  = 8'h00;
        cyc(3);
        reset = 1'b0;
        // 1: quiet after reset
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("reset_state", {bus.sample_in_valid, bus.next_sample, timeout, bus.sample_in,
                                  bus.stored_count, bus.view_idx, state}, '0);
        end
        // 2: single capture
        store_sample(8'hA5, 3'd1, 3'd0);
        check("t2_state", {30'd0, state}, 32'd0);
        check("t2_count", {29'd0, bus.stored_count}, 32'd1);
        // 3: saturation and index wrap
        do_reset();
        for (int i = 0; i < 6; i++)
            store_sample(8'(i + 1), (i < 5) ? 3'(i + 1) : 3'd5, (i < 5) ? 3'(i) : 3'd0);
        check("t3_sat", {29'd0, bus.stored_count}, 32'd5);
        // 4: next presses
        do_reset();
        press(1, 3);
        cyc(4);
        check("t4_no_next", {29'd0, bus.view_idx}, 32'd0);
        store_sample(8'h0A, 3'd1, 3'd0);
        store_sample(8'h0B, 3'd2, 3'd1);
        for (int i = 0; i < 4; i++) begin
            push(K_NEXT, 8'h0B, 3'd2, (i < 3) ? 3'(i + 2) : 3'd0);
            press(1, 20);
            cyc(4);
        end
        check("t4_view", {29'd0, bus.view_idx}, 32'd0);
        // 5: timeout, then sample_ready on the expiry cycle
        do_reset();
        push(K_TO, 8'h00, 3'd0, 3'd0);
        press(0, 1);
        wait_state(2'd1, "t5_armed");
        n = 0;
        while (state == 2'd1 && n < 40) begin cyc(1); n++; end
        check("t5_armed_cycles", n, 16);
        check("t5_timeout_pulse", {31'd0, timeout}, 32'd1);
        cyc(3);
        press(0, 1);
        wait_state(2'd1, "t5_armed2");
        cyc(15);
        push(K_STORE, 8'h3C, 3'd1, 3'd0);
        bus.sample_ready = 1'b1; bus.sample_data = 8'h3C;
        cyc(1);
        bus.sample_ready = 1'b0; bus.sample_data = 8'h00;
        cyc(3);
        check("t5_state", {30'd0, state}, 32'd0);
        // 6: auto-scroll
        do_reset();
        store_sample(8'h11, 3'd1, 3'd0);
        store_sample(8'h22, 3'd2, 3'd1);
        store_sample(8'h33, 3'd3, 3'd2);
        push(K_NEXT, 8'h33, 3'd3, 3'd3);
        push(K_NEXT, 8'h33, 3'd3, 3'd4);
        auto_en = 1'b1;
        wait_state(2'd2, "t6_auto");
        wait_next(t0);
        wait_next(t1);
        check("t6_period", t1 - t0, TICK_DIV);
        store_sample(8'h44, 3'd4, 3'd3);
        wait_state(2'd2, "t6_auto_resume");
        push(K_NEXT, 8'h44, 3'd4, 3'd4);
        wait_next(t0);
        auto_en = 1'b0;
        wait_state(2'd0, "t6_idle");
        cyc(30);
        // asynchronous reset mid-cycle from AUTO
        auto_en = 1'b1;
        wait_state(2'd2, "t1_auto_again");
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check("async_reset", {bus.sample_in_valid, bus.next_sample, timeout, bus.sample_in,
                                 bus.stored_count, bus.view_idx, state}, '0);
        auto_en = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(5);
        check("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/stash_sequencer.md
Name: stash_sequencer

Overview:
Control sequencer that drives the sample stash from user controls and a sample source.
- Converts raw push-buttons into single-cycle store and next strobes.
- Arms a one-shot capture of the next sample offered by the source, and times it out if none arrives.
- Runs an auto-scroll mode that steps through stored samples at a fixed period.
- Mirrors the stash's fill count and exposed index for display logic on the BASYS3 top level.

Parameters:
DEPTH, 5, number of stash entries; must match the stash; minimum 2.
TICK_DIV, 100000000, auto-scroll period in clk cycles (1 s at 100 MHz); minimum 2.
TIMEOUT, 50000000, maximum clk cycles spent in ARMED waiting for sample_ready; minimum 1.

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset  in  1  asynchronous, active-high reset.
btn_store  in  1  raw store button, asynchronous to clk.
btn_next  in  1  raw next button, asynchronous to clk.
auto_en  in  1  auto-scroll switch, asynchronous to clk.
sample_ready  in  1  source strobe, synchronous to clk; sample_data valid while high.
sample_data  in  8  sample offered by the source.
sample_in_valid  out  1  one-cycle store strobe to the stash.
sample_in  out  8  registered copy of sample_data, aligned with sample_in_valid.
next_sample  out  1  one-cycle advance strobe to the stash.
stored_count  out  $clog2(DEPTH+1)  valid entries in the stash, saturating at DEPTH.
view_idx  out  $clog2(DEPTH)  index the stash is currently exposing.
state  out  2  FSM state: 0 IDLE, 1 ARMED, 2 AUTO.
timeout  out  1  one-cycle pulse when an armed capture expires.

Behaviour:
- Reset is asynchronous and active-high. It forces all outputs, write_idx, the tick counter, the timeout counter and the synchronizer flops to 0, and the FSM to IDLE. Reset mid-capture or mid-scroll abandons the operation with no strobe emitted.
- Button and switch inputs pass through a 2-flop synchronizer plus a history flop. A button event is the rising edge of the synchronized signal.
  - Timing: input first sampled high at clock edge k gives an internal event at edge k+1 and a registered output strobe asserted after edge k+2.
  - Holding a button produces exactly one event.
- All outputs are registered.
- IDLE:
  - store event -> ARMED; clear the timeout counter.
  - next event with stored_count>0 -> emit next_sample; stay in IDLE.
  - next event with stored_count=0 -> ignored.
  - synchronized auto_en=1 and no store event -> AUTO; tick counter cleared.
- ARMED:
  - sample_ready=1 -> capture sample_data into sample_in, assert sample_in_valid for one cycle, go to IDLE.
  - store event -> cancel, go to IDLE with no strobe.
  - timeout counter reaches TIMEOUT-1 with no sample_ready -> timeout pulse for one cycle, go to IDLE.
  - sample_ready wins over a store event and over timeout expiry in the same cycle.
  - next events are ignored.
- AUTO:
  - Tick counter counts 0..TICK_DIV-1. At terminal count with stored_count>0, emit next_sample and wrap the counter to 0.
  - synchronized auto_en=0 -> IDLE; counter cleared.
  - store event -> ARMED, which takes priority over auto_en=0.
  - next events are ignored.
  - After the capture returns to IDLE, AUTO is re-entered on the next cycle if auto_en is still 1.
- Index tracking, mirroring the stash pointers:
  - On sample_in_valid: view_idx <= write_idx; write_idx advances DEPTH-1 -> 0; stored_count increments and saturates at DEPTH.
  - On next_sample: view_idx advances and wraps at DEPTH-1 -> 0. It wraps at DEPTH, not at stored_count, matching the stash.
- sample_in_valid and next_sample are never asserted in the same cycle.
- The width of stored_count handles exactly DEPTH; there is no overflow path.

Optional Feature:
Macro STASH_SEQ_CLEAR_EN.
- Defined: adds input btn_clear (raw, synchronized like the other buttons) and output stash_clear (1 bit, reset 0).
  - A clear event in IDLE pulses stash_clear for one cycle and zeros stored_count, view_idx and write_idx on the same edge.
  - Clear events in ARMED or AUTO are ignored.
  - stash_clear is ORed into the stash reset by the top level.
- Undefined: neither port exists and no clear path is built.

Test Plan:
1. Reset release with all inputs 0 -> all outputs 0 and state=0 for 10 cycles. Assert reset asynchronously mid-cycle -> outputs drop to 0 before the next edge.
2. btn_store pulse, then sample_ready=1 with sample_data=0xA5 four cycles later -> exactly one sample_in_valid cycle with sample_in=0xA5; stored_count=1, view_idx=0, state returns to 0.
3. Store 6 samples 0x01..0x06 with DEPTH=5 -> stored_count saturates at 5; view_idx sequence 0,1,2,3,4,0.
4. btn_next with stored_count=0 -> no next_sample. After 2 stores, 4 next presses -> view_idx 1->2->3->4->0; one pulse per press even when the button is held for 20 cycles.
5. TIMEOUT=16, arm with no sample_ready -> timeout pulses on the 16th cycle in ARMED and state=0. Repeat with sample_ready on the expiry cycle -> store occurs and no timeout pulse.
6. TICK_DIV=8, stored_count=3, auto_en=1 -> next_sample every 8 cycles. btn_store during AUTO -> ARMED; after the capture, AUTO resumes. auto_en=0 -> IDLE and no further strobes.
